sysid_ext: RTL and testbench

//  Parametrised system-ID and uptime peripheral. It is an Avalon-MM slave on the SOPC fabric.

---
 rtl/sysid_pkg.sv | 31 +++
 rtl/sysid_ext_if.sv | 24 ++
 rtl/sysid_uptime_counter.sv | 56 +++++
 rtl/sysid_ext.sv | 90 +++++++++
 tb/tb_sysid_ext.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID / uptime peripheral: word offsets, CTRL bits,
// and the byte-lane merge used by writable registers.
package sysid_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam logic [2:0] OFS_ID      = 3'd0;
    localparam logic [2:0] OFS_TS      = 3'd1;
    localparam logic [2:0] OFS_VER     = 3'd2;
    localparam logic [2:0] OFS_SCRATCH = 3'd3;
    localparam logic [2:0] OFS_UP_LO   = 3'd4;
    localparam logic [2:0] OFS_UP_HI   = 3'd5;
    localparam logic [2:0] OFS_CTRL    = 3'd6;
    localparam logic [2:0] OFS_DIV     = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sysid_ext_if.sv
// Avalon-MM slave bundle for the system-ID peripheral (no waitrequest, fixed latency 1).
interface sysid_ext_if;
    import sysid_pkg::*;

    logic              chipselect;
    logic [2:0]        address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output chipselect, address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  chipselect, address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Prescaled 64-bit uptime counter with a hi-half shadow captured on a LO read,
// so software always sees a coherent 64-bit value.
module sysid_uptime_counter
    import sysid_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              snap_i,
    output logic [DATA_W-1:0] cnt_lo_o,
    output logic [DATA_W-1:0] shadow_o
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic        tick;

    assign tick = en_i && (presc_q == PRESC_LAST);

    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        shadow_d = snap_i ? cnt_q[63:32] : shadow_q;
        if (clr_i) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (en_i) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (tick) cnt_d = cnt_q + 64'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt_lo_o = cnt_q[31:0];
    assign shadow_o = shadow_q;

endmodule

// File: rtl/sysid_ext.sv
// System-ID / uptime Avalon-MM slave: bus decode, scratch and CTRL registers,
// registered read mux with a one-cycle readdatavalid pulse.
module sysid_ext
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h5AA2_0D2F,
    parameter logic [31:0] TIMESTAMP   = 32'h4742_3DC3,
    parameter logic [31:0] VERSION     = 32'h0002_0000,
    parameter int unsigned TICK_DIV    = 1,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    sysid_ext_if.slave  bus
);

    logic              rd_acc, wr_acc, clr;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic              en_q, en_d;
    logic [DATA_W-1:0] readdata_q, readdata_d, rdata_mux;
    logic              rvalid_q;
    logic [DATA_W-1:0] cnt_lo, shadow;

    assign rd_acc = bus.chipselect & bus.read;
    assign wr_acc = bus.chipselect & bus.write;

    always_comb begin
        scratch_d = scratch_q;
        en_d      = en_q;
        clr       = 1'b0;
        if (wr_acc) begin
            case (bus.address)
                OFS_SCRATCH: scratch_d = apply_be(scratch_q, bus.writedata, bus.byteenable);
                OFS_CTRL: begin
                    en_d = bus.writedata[CTRL_EN];
                    clr  = bus.writedata[CTRL_CLR];
                end
                default: ;
            endcase
        end
    end

    // Muxed from pre-edge state, so a coincident write or tick is not visible to this read.
    always_comb begin
        rdata_mux = '0;
        case (bus.address)
            OFS_ID:      rdata_mux = SYSTEM_ID;
            OFS_TS:      rdata_mux = TIMESTAMP;
            OFS_VER:     rdata_mux = VERSION;
            OFS_SCRATCH: rdata_mux = scratch_q;
            OFS_UP_LO:   rdata_mux = cnt_lo;
            OFS_UP_HI:   rdata_mux = shadow;
            OFS_CTRL:    rdata_mux = {31'd0, en_q};
            OFS_DIV:     rdata_mux = 32'(TICK_DIV);
            default:     rdata_mux = '0;
        endcase
    end

    assign readdata_d = rd_acc ? rdata_mux : readdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q  <= SCRATCH_RST;
            en_q       <= 1'b1;
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            scratch_q  <= scratch_d;
            en_q       <= en_d;
            readdata_q <= readdata_d;
            rvalid_q   <= rd_acc;
        end
    end

    sysid_uptime_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_uptime (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (en_q),
        .clr_i    (clr),
        .snap_i   (rd_acc && (bus.address == OFS_UP_LO)),
        .cnt_lo_o (cnt_lo),
        .shadow_o (shadow)
    );

    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_ext.sv
// Directed bench for sysid_ext: one default instance (TICK_DIV=1) and one with TICK_DIV=4.
module tb_sysid_ext;
    import sysid_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    sysid_ext_if bus  ();
    sysid_ext_if bus4 ();

    sysid_ext dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    sysid_ext #(.TICK_DIV(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_data;
    logic        rd_valid;

    task automatic drive(input int d, input logic cs, input logic rd, input logic wr,
                         input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (d == 0) begin
            bus.chipselect = cs; bus.read = rd; bus.write = wr;
            bus.address = a; bus.writedata = wd; bus.byteenable = be;
        end else begin
            bus4.chipselect = cs; bus4.read = rd; bus4.write = wr;
            bus4.address = a; bus4.writedata = wd; bus4.byteenable = be;
        end
    endtask

    task automatic get(input int d, output logic [31:0] data, output logic v);
        data = (d == 0) ? bus.readdata : bus4.readdata;
        v    = (d == 0) ? bus.readdatavalid : bus4.readdatavalid;
    endtask

    // Called at a negedge; the access is sampled on the next posedge, result taken at the following negedge.
    task automatic bus_read(input int d, input logic [2:0] a, output logic [31:0] data, output logic v);
        drive(d, 1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        get(d, data, v);
    endtask

    task automatic bus_write(input int d, input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        drive(d, 1'b1, 1'b0, 1'b1, a, wd, be);
        @(posedge clk);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_read(input int d, input logic [2:0] a, input logic [31:0] exp, input string name);
        bus_read(d, a, rd_data, rd_valid);
        checks++;
        if (rd_data !== exp || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=1", name, rd_data, rd_valid, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.readdata !== 32'd0 || bus.readdatavalid !== 1'b0 ||
            bus4.readdata !== 32'd0 || bus4.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_outputs: got %h/%b %h/%b, expected 00000000/0 both", tag,
                     bus.readdata, bus.readdatavalid, bus4.readdata, bus4.readdatavalid);
        end
        check_read(0, OFS_UP_LO,   32'd0, {tag, "_uptime_lo"});
        check_read(0, OFS_UP_HI,   32'd0, {tag, "_uptime_hi"});
        check_read(0, OFS_SCRATCH, 32'd0, {tag, "_scratch"});
        check_read(0, OFS_CTRL,    32'd1, {tag, "_ctrl"});
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_values("reset");
    endtask

    task automatic test_ids();
        logic [2:0]  ofs [4];
        logic [31:0] exp [4];
        ofs = '{OFS_ID, OFS_TS, OFS_VER, OFS_DIV};
        exp = '{32'h5AA2_0D2F, 32'h4742_3DC3, 32'h0002_0000, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            check_read(0, ofs[i], exp[i], $sformatf("id_ofs%0d", ofs[i]));
            idle(1);
            checks++;
            if (bus.readdatavalid !== 1'b0) begin
                errors++;
                $display("FAIL id_valid_len_ofs%0d: valid=%b one clk later, expected 0", ofs[i], bus.readdatavalid);
            end
        end
    endtask

    task automatic test_scratch();
        bus_write(0, OFS_SCRATCH, 32'hDEAD_BEEF, 4'b1111);
        bus_write(0, OFS_SCRATCH, 32'h0000_0011, 4'b0001);
        check_read(0, OFS_SCRATCH, 32'hDEAD_BE11, "scratch_be");
        bus_write(0, OFS_SCRATCH, 32'hAB00_0000, 4'b1000);
        check_read(0, OFS_SCRATCH, 32'hABAD_BE11, "scratch_be_top");
        bus_write(0, OFS_SCRATCH, 32'hDEAD_BEEF, 4'b1000);
        check_read(0, OFS_SCRATCH, 32'hDEAD_BE11, "scratch_restore");
    endtask

    task automatic test_back_to_back();
        drive(0, 1'b1, 1'b1, 1'b0, OFS_SCRATCH, 32'd0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, OFS_VER, 32'd0, 4'd0);
        get(0, rd_data, rd_valid);
        checks++;
        if (rd_data !== 32'hDEAD_BE11 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b, expected deadbe11/1", rd_data, rd_valid);
        end
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        get(0, rd_data, rd_valid);
        checks++;
        if (rd_data !== 32'h0002_0000 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got %h/%b, expected 00020000/1", rd_data, rd_valid);
        end
        idle(1);
        get(0, rd_data, rd_valid);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0002_0000) begin
            errors++;
            $display("FAIL b2b_after: got %h/%b, expected 00020000/0 (held)", rd_data, rd_valid);
        end
    endtask

    task automatic test_ro_write();
        bus_write(0, OFS_ID, 32'hFFFF_FFFF, 4'b1111);
        check_read(0, OFS_ID, 32'h5AA2_0D2F, "ro_write_id");
        bus_write(0, OFS_DIV, 32'hFFFF_FFFF, 4'b1111);
        check_read(0, OFS_DIV, 32'h0000_0001, "ro_write_div");
        check_read(0, OFS_SCRATCH, 32'hDEAD_BE11, "ro_write_no_side_effect");
    endtask

    task automatic test_read_write_same();
        drive(0, 1'b1, 1'b1, 1'b1, OFS_SCRATCH, 32'h1234_5678, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        get(0, rd_data, rd_valid);
        checks++;
        if (rd_data !== 32'hDEAD_BE11 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rw_same_old: got %h/%b, expected deadbe11/1", rd_data, rd_valid);
        end
        check_read(0, OFS_SCRATCH, 32'h1234_5678, "rw_same_new");
    endtask

    task automatic test_uptime_wrap();
        force dut.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.u_uptime.cnt_q;
        check_read(0, OFS_UP_LO, 32'hFFFF_FFFF, "snap_lo_on_tick");
        check_read(0, OFS_UP_HI, 32'h0000_0000, "snap_hi_no_tear");
        force dut.u_uptime.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.u_uptime.cnt_q;
        idle(1);
        check_read(0, OFS_UP_LO, 32'h0000_0000, "wrap_lo");
        check_read(0, OFS_UP_HI, 32'h0000_0000, "wrap_hi");
    endtask

    task automatic test_prescaler();
        bus_write(1, OFS_CTRL, 32'h3, 4'b1111);
        idle(40);
        check_read(1, OFS_UP_LO, 32'd10, "div4_40clk");
        bus_write(1, OFS_CTRL, 32'h0, 4'b1111);
        idle(20);
        check_read(1, OFS_UP_LO, 32'd10, "div4_frozen");
        check_read(1, OFS_CTRL, 32'd0, "ctrl_en_off");
        bus_write(1, OFS_CTRL, 32'h3, 4'b1111);
        check_read(1, OFS_UP_LO, 32'd0, "div4_clear");
        idle(3);
        check_read(1, OFS_UP_LO, 32'd1, "div4_resume");
        check_read(1, OFS_CTRL, 32'd1, "ctrl_clr_reads0");
        check_read(1, OFS_DIV, 32'd4, "div4_reg");
    endtask

    task automatic test_reset_mid_read();
        bus_write(0, OFS_CTRL, 32'h0, 4'b1111);
        drive(0, 1'b1, 1'b1, 1'b0, OFS_SCRATCH, 32'd0, 4'd0);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_read_reset: got %h/%b, expected 00000000/0", bus.readdata, bus.readdatavalid);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        reset_n = 1'b1;
        check_reset_values("post_reset");
    endtask

    initial begin
        test_reset();
        test_ids();
        test_scratch();
        test_back_to_back();
        test_ro_write();
        test_read_write_same();
        test_uptime_wrap();
        test_prescaler();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
